dds_sweep_ctrl: RTL

Sequencer that configures the triangle DDS (freq_word/amplitude inputs) to run a timed linear frequency sweep.
- Latches a sweep profile on start.
- Steps freq_word from f_start to f_stop, holding each step for a programmable dwell.
- Optionally fades amplitude in and out around the sweep.
- Sits between the control/register logic and triangle_dds; its outputs drive the DDS directly.

---
 rtl/dds_ctrl_pkg.sv | 16 +
 rtl/dds_dwell_timer.sv | 21 ++
 rtl/dds_sweep_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dds_ctrl_pkg.sv
// Shared types and defaults for the DDS sweep controller.
package dds_ctrl_pkg;
  localparam int FW_W_DEF  = 32;
  localparam int AMP_W_DEF = 16;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    SWEEP     = 3'd2,
    RAMP_DOWN = 3'd3,
    DONE      = 3'd4
  } state_t;
endpackage

// File: rtl/dds_dwell_timer.sv
// Per-step dwell down-counter; a programmed dwell of 0 behaves as 1.
module dds_dwell_timer #(
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  output logic               expire
);
  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           cnt <= '0;
    else if (load)                        cnt <= (dwell == '0) ? DWELL_W'(1) : dwell;
    else if (en && (cnt > DWELL_W'(1)))   cnt <= cnt - DWELL_W'(1);
  end

  assign expire = en && (cnt <= DWELL_W'(1));
endmodule

// File: rtl/dds_sweep_ctrl.sv
// Timed linear frequency sweep sequencer driving triangle_dds freq_word/amplitude.
// Amplitude fade in/out around the sweep is enabled by defining SWEEP_AMP_FADE_EN.
module dds_sweep_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int FW_W    = FW_W_DEF,
  parameter int AMP_W   = AMP_W_DEF,
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [FW_W-1:0]    f_start,
  input  logic [FW_W-1:0]    f_stop,
  input  logic [FW_W-1:0]    f_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [AMP_W-1:0]   amp_target,
  input  logic [AMP_W-1:0]   amp_step,
  output logic [FW_W-1:0]    freq_word,
  output logic [AMP_W-1:0]   amplitude,
  output logic               upd,
  output logic               busy,
  output logic               done,
  output logic [15:0]        step_cnt
);
  state_t             state;
  logic [FW_W-1:0]    stop_q, step_q, nxt;
  logic [DWELL_W-1:0] dwell_q;
  logic [AMP_W-1:0]   tgt_q;
  logic               dir_q;
  logic [FW_W:0]      sum, dif;
  logic               last, tmr_load, tmr_en, tmr_exp, sweep_entry;

  // Next tuning word, evaluated one bit wider so wrap shows up as a carry/borrow.
  assign sum = {1'b0, freq_word} + {1'b0, step_q};
  assign dif = {1'b0, freq_word} - {1'b0, step_q};
  always_comb begin
    nxt = stop_q;
    if (dir_q == DIR_UP) begin
      if (!sum[FW_W] && (sum[FW_W-1:0] < stop_q)) nxt = sum[FW_W-1:0];
    end else if (dir_q == DIR_DOWN) begin
      if (!dif[FW_W] && (dif[FW_W-1:0] > stop_q)) nxt = dif[FW_W-1:0];
    end
  end

  assign last   = (freq_word == stop_q) || (step_q == '0);
  assign tmr_en = (state == SWEEP) && !abort;

`ifdef SWEEP_AMP_FADE_EN
  logic [AMP_W-1:0] astep_q, amp_up, amp_dn;
  logic [AMP_W:0]   amp_sum;
  assign amp_sum     = {1'b0, amplitude} + {1'b0, astep_q};
  assign amp_up      = ((astep_q == '0) || (amp_sum > {1'b0, tgt_q})) ? tgt_q : amp_sum[AMP_W-1:0];
  assign amp_dn      = ((astep_q == '0) || (amplitude <= astep_q)) ? '0 : amplitude - astep_q;
  assign sweep_entry = (state == RAMP_UP) && !abort && (amplitude == tgt_q);
`else
  logic unused_amp_step;
  assign unused_amp_step = ^amp_step;
  assign sweep_entry     = (state == IDLE) && start;
`endif

  assign tmr_load = sweep_entry || (tmr_en && tmr_exp && !last);

  dds_dwell_timer #(.DWELL_W(DWELL_W)) u_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .en     (tmr_en),
    .dwell  ((state == IDLE) ? dwell : dwell_q),
    .expire (tmr_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      freq_word <= '0;
      amplitude <= '0;
      upd       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      step_cnt  <= '0;
      stop_q    <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      tgt_q     <= '0;
      dir_q     <= DIR_UP;
`ifdef SWEEP_AMP_FADE_EN
      astep_q   <= '0;
`endif
    end else begin
      upd  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          stop_q    <= f_stop;
          step_q    <= f_step;
          dwell_q   <= dwell;
          tgt_q     <= amp_target;
          dir_q     <= (f_stop >= f_start) ? DIR_UP : DIR_DOWN;
          freq_word <= f_start;
          upd       <= 1'b1;
          step_cnt  <= 16'd1;
          busy      <= 1'b1;
`ifdef SWEEP_AMP_FADE_EN
          astep_q   <= amp_step;
          amplitude <= '0;
          state     <= RAMP_UP;
`else
          amplitude <= amp_target;
          state     <= SWEEP;
`endif
        end
`ifdef SWEEP_AMP_FADE_EN
        RAMP_UP: begin
          if (abort)                    state     <= RAMP_DOWN;
          else if (amplitude == tgt_q)  state     <= SWEEP;
          else                          amplitude <= amp_up;
        end
        RAMP_DOWN: begin
          if (amplitude == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            amplitude <= amp_dn;
          end
        end
`endif
        SWEEP: begin
          if (abort || (tmr_exp && last)) begin
`ifdef SWEEP_AMP_FADE_EN
            state     <= RAMP_DOWN;
`else
            amplitude <= '0;
            state     <= DONE;
            done      <= 1'b1;
`endif
          end else if (tmr_exp) begin
            freq_word <= nxt;
            upd       <= 1'b1;
            if (step_cnt != 16'hFFFF) step_cnt <= step_cnt + 16'd1;
          end
        end
        DONE: begin
          amplitude <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
